// File: rtl/uxa_ps2_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, framing FSM with start/parity/stop checks,
// inter-edge watchdog and a first-word-fall-through receive FIFO with valid/ready output.
module uxa_ps2_rx #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY_EN      = 1,
  parameter int unsigned ODD_PARITY     = 1,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          sys_clk_i,
  input  logic                          reset_i,
  input  logic                          ps2_c_i,
  input  logic                          ps2_d_i,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          busy_o,
  output logic                          err_parity_o,
  output logic                          err_frame_o,
  output logic                          err_timeout_o,
  output logic                          err_overrun_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          ParEn  = (PARITY_EN != 0);
  localparam bit          OddPar = (ODD_PARITY != 0);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] c_sync_q, d_sync_q;
  logic                   c_prev_q;
  logic                   c_s, d_s, sample;

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      c_prev_q <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[SYNC_STAGES-2:0], ps2_c_i};
      d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], ps2_d_i};
      c_prev_q <= c_s;
    end
  end

  assign c_s    = c_sync_q[SYNC_STAGES-1];
  assign d_s    = d_sync_q[SYNC_STAGES-1];
  assign sample = c_prev_q & ~c_s;

  state_e                 state_q, state_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_ok_q, par_ok_d;
  logic [WdW-1:0]         wdog_q, wdog_d;
  logic                   push_req_q, push_req_d;
  logic                   err_par_q, err_par_d;
  logic                   err_frm_q, err_frm_d;
  logic                   err_to_q, err_to_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_ok_d   = par_ok_q;
    wdog_d     = wdog_q;
    push_req_d = 1'b0;
    err_par_d  = 1'b0;
    err_frm_d  = 1'b0;
    err_to_d   = 1'b0;

    if (state_q != StIdle) wdog_d = wdog_q + WdW'(1);
    if (sample) wdog_d = '0;

    unique case (state_q)
      StIdle: begin
        if (sample && !d_s) begin
          state_d   = StData;
          bit_cnt_d = '0;
          par_ok_d  = 1'b1;
        end
      end
      StData: begin
        if (sample) begin
          // LSB arrives first, so shifting in at the MSB leaves the payload LSB-aligned
          shift_d   = {d_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BitW'(1);
          if (bit_cnt_q == BitW'(DATA_BITS - 1)) state_d = ParEn ? StParity : StStop;
        end
      end
      StParity: begin
        if (sample) begin
          par_ok_d = (^shift_q ^ d_s) == OddPar;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (sample) begin
          if (!d_s)           err_frm_d  = 1'b1;
          else if (!par_ok_q) err_par_d  = 1'b1;
          else                push_req_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A sample in the expiry cycle keeps the frame alive
    if (state_q != StIdle && !sample && wdog_q == WdW'(TIMEOUT_CYCLES - 1)) begin
      state_d  = StIdle;
      err_to_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_ok_q   <= 1'b1;
      wdog_q     <= '0;
      push_req_q <= 1'b0;
      err_par_q  <= 1'b0;
      err_frm_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      wdog_q     <= wdog_d;
      push_req_q <= push_req_d;
      err_par_q  <= err_par_d;
      err_frm_q  <= err_frm_d;
      err_to_q   <= err_to_d;
    end
  end

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ovr_q, ovr_d;
  logic                 pop, full, push_ok;

  assign pop     = valid_q & ready_i;
  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign push_ok = push_req_q & (~full | pop);

  always_comb begin
    ovr_d   = push_req_q & full & ~pop;
    wr_d    = wr_q + PtrW'(push_ok);
    rd_d    = rd_q + PtrW'(pop);
    count_d = count_q + CntW'(push_ok) - CntW'(pop);
    valid_d = (count_d != '0);
    data_d  = data_q;
    if (count_d != '0) begin
      // The new head may be the slot being written this cycle
      data_d = (push_ok && rd_d == wr_q) ? shift_q : mem_q[rd_d];
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push_ok) mem_q[wr_q] <= shift_q;
  end

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign count_o       = count_q;
  assign busy_o        = (state_q != StIdle);
  assign err_parity_o  = err_par_q;
  assign err_frame_o   = err_frm_q;
  assign err_timeout_o = err_to_q;
  assign err_overrun_o = ovr_q;

endmodule

// File: tb/tb_uxa_ps2_rx.sv
// Bench for uxa_ps2_rx: PS/2 frames are bit-banged on the pins; expected bytes and error kinds
// are queued at issue time and matched by independent output monitors.
module tb_uxa_ps2_rx;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 1000;
  localparam int unsigned Sync  = 2;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2_c   = 1'b1;
  logic       ps2_d   = 1'b1;
  logic       ready   = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, busy_o;
  logic [2:0] count_o;
  logic       err_parity_o, err_frame_o, err_timeout_o, err_overrun_o;

  uxa_ps2_rx #(
    .DATA_BITS(8), .PARITY_EN(1), .ODD_PARITY(1), .SYNC_STAGES(Sync),
    .TIMEOUT_CYCLES(Tmo), .FIFO_DEPTH(Depth)
  ) dut (
    .sys_clk_i(sys_clk), .reset_i(reset), .ps2_c_i(ps2_c), .ps2_d_i(ps2_d),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready), .count_o(count_o),
    .busy_o(busy_o), .err_parity_o(err_parity_o), .err_frame_o(err_frame_o),
    .err_timeout_o(err_timeout_o), .err_overrun_o(err_overrun_o)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_data[$];
  logic [3:0] exp_err[$];   // one-hot {overrun, timeout, frame, parity}
  int unsigned last_fall_cyc = 0;
  int unsigned to_cyc = 0;

  logic [3:0] err_vec, err_prev;
  assign err_vec = {err_overrun_o, err_timeout_o, err_frame_o, err_parity_o};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Data monitor: every accepted head byte must match the oldest expected byte
  always @(negedge sys_clk) begin
    if (!reset && valid_o && ready) begin
      if (exp_data.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_data: got 0x%0h, expected no byte", data_o);
      end else begin
        check("pop_data", data_o, exp_data.pop_front());
      end
    end
  end

  // Error monitor: every pulse must match the oldest expected error and last one cycle
  always @(negedge sys_clk) begin
    err_prev <= err_vec;
    if (!reset && err_vec != 4'b0) begin
      if (err_timeout_o) to_cyc = cyc;
      if (exp_err.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL err_kind: got %b, expected no error", err_vec);
      end else begin
        check("err_kind", err_vec, exp_err.pop_front());
      end
      check("err_one_cycle", err_prev, 4'b0);
    end
  end

  task automatic ps2_bit(input logic b, input int unsigned half);
    ps2_d = b;
    repeat (half) @(posedge sys_clk);
    #1 ps2_c = 1'b0;
    last_fall_cyc = cyc;
    repeat (half) @(posedge sys_clk);
    #1 ps2_c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int unsigned nbits);
    logic [10:0]  bits;
    int unsigned  half;
    half     = $urandom_range(6, 25);
    bits[0]  = 1'b0;
    bits[8:1] = b;
    bits[9]  = ~(^b) ^ bad_par;
    bits[10] = ~bad_stop;
    for (int i = 0; i < int'(nbits); i++) ps2_bit(bits[i], half);
    ps2_d = 1'b1;
  endtask

  task automatic wait_err_empty();
    int n = 0;
    while (exp_err.size() != 0 && n < 3000) begin
      @(posedge sys_clk);
      n++;
    end
    checks++;
    if (exp_err.size() != 0) begin
      errors++;
      $display("FAIL err_missing: got no pulse, expected %b", exp_err[0]);
      exp_err.delete();
    end
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad parity and bad stop (frame error wins)
  task automatic frame(input logic [7:0] b, input int kind);
    if (kind >= 2)                     exp_err.push_back(4'b0010);
    else if (kind == 1)                exp_err.push_back(4'b0001);
    else if (exp_data.size() == Depth) exp_err.push_back(4'b1000);
    else                               exp_data.push_back(b);
    send_frame(b, kind[0], kind[1], 11);
    repeat (50) @(posedge sys_clk);
    wait_err_empty();
  endtask

  task automatic drain(input logic keep);
    int n = 0;
    #1 ready = 1'b1;
    while (exp_data.size() != 0 && n < 200) begin
      @(posedge sys_clk);
      n++;
    end
    @(posedge sys_clk);
    #1 if (!keep) ready = 1'b0;
    check("drain_valid", valid_o, 1'b0);
    check("drain_count", count_o, 3'd0);
    exp_data.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish, expected finish before 90000 cycles");
    $fatal(1, "bench timed out");
  end

  initial begin
    int d;
    logic [7:0] rb;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_valid", valid_o, 1'b0);
    check("rst_count", count_o, 3'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_data", data_o, 8'h00);
    check("rst_err", err_vec, 4'b0);
    reset = 1'b0;
    repeat (5) @(posedge sys_clk);

    // Single good frame, held then accepted in one cycle
    frame(8'h1C, 0);
    check("t1_valid", valid_o, 1'b1);
    check("t1_data", data_o, 8'h1C);
    check("t1_count", count_o, 3'd1);
    @(posedge sys_clk);
    #1 ready = 1'b1;
    @(posedge sys_clk);
    #1 ready = 1'b0;
    check("t1_valid_after", valid_o, 1'b0);
    check("t1_count_after", count_o, 3'd0);

    // Parity error, then a correct frame
    frame(8'h1C, 1);
    check("t2_valid", valid_o, 1'b0);
    frame(8'hF0, 0);
    check("t2_data", data_o, 8'hF0);
    drain(1'b0);

    // Stop bit error
    frame(8'h5A, 2);
    check("t3_busy", busy_o, 1'b0);
    check("t3_count", count_o, 3'd0);

    // Watchdog: start plus four data bits, then the clock stays high
    exp_err.push_back(4'b0100);
    send_frame(8'h12, 1'b0, 1'b0, 5);
    wait_err_empty();
    d = int'(to_cyc - last_fall_cyc) - int'(Sync + 1);
    checks++;
    if (d < int'(Tmo) - 1 || d > int'(Tmo) + 1) begin
      errors++;
      $display("FAIL timeout_window: got %0d cycles, required %0d..%0d", d, Tmo - 1, Tmo + 1);
    end
    check("t4_busy", busy_o, 1'b0);
    frame(8'h12, 0);
    check("t4_data", data_o, 8'h12);
    drain(1'b0);

    // Overrun on the fifth frame, then ordered drain
    for (int i = 1; i <= 5; i++) frame(8'(i), 0);
    check("t5_count", count_o, 3'(Depth));
    drain(1'b0);

    // Asynchronous reset mid-frame with two bytes buffered
    frame(8'hA1, 0);
    frame(8'hB2, 0);
    check("t6_count", count_o, 3'd2);
    for (int i = 0; i < 5; i++) ps2_bit((i == 0) ? 1'b0 : 1'b0, 12);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", valid_o, 1'b0);
    check("t6_rst_count", count_o, 3'd0);
    check("t6_rst_busy", busy_o, 1'b0);
    check("t6_rst_data", data_o, 8'h00);
    exp_data.delete();
    exp_err.delete();
    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b0;
    // Remaining bits of 0xF0: data 1,1,1,1, parity 1, stop 1
    for (int i = 0; i < 6; i++) ps2_bit(1'b1, 12);
    repeat (Tmo + 200) @(posedge sys_clk);
    check("t6_busy", busy_o, 1'b0);
    check("t6_count_after", count_o, 3'd0);
    frame(8'h33, 0);
    check("t6_data", data_o, 8'h33);
    drain(1'b0);

    // Randomised frames, error kinds and consumer readiness
    for (int i = 0; i < 14; i++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 1) == 1) drain(1'b1);
      else #1 ready = 1'b0;
      frame(rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    drain(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
